scan_tap_ctrl: RTL
==================

// Module: scan_tap_ctrl
// PURPOSE
//  Byte-level sequencer for the scan chain. Takes received UART bytes tagged
//  by TMS (0 = address, 1 = data). Decodes SYNC/address messages to select
//  one of NUM_TAPS taps, then serialises data bytes onto TCK/TDI, LSB first.
//  Sits between the UART receiver and the tap select/scan pins in fpga_top.
// PARAMETERS
//  NUM_TAPS  4      number of taps; TAP_SEL width; legal addresses 0..NUM_TAPS-1
//  TCK_DIV   2      CLK cycles per TCK half-period (>=1)
//  SYNC      8'hA5  address byte that opens an address message
//  DESEL     8'h5A  address byte that deselects the current tap
// PORTS
//  CLK       in   1         system clock
//  TRST      in   1         async reset, active-high
//  RX_DATA   in   8         received byte
//  RX_VALID  in   1         byte valid; accepted when RX_VALID & RX_READY
//  TMS       in   1         byte type, sampled at accept: 0 address, 1 data
//  RX_READY  out  1         low only while shifting
//  TAP_SEL   out  NUM_TAPS  one-hot tap select, all-zero = none
//  TCK       out  1         scan clock
//  TDI       out  1         scan data out, LSB first
//  TDO       in   1         scan data in
//  TX_DATA   out  8         captured TDO byte
//  TX_VALID  out  1         one-cycle strobe, TX_DATA valid
//  BUSY      out  1         high in SHIFT
// BEHAVIOUR
//  Reset: state IDLE, TAP_SEL=0, TCK=0, TDI=1, RX_READY=1, TX_VALID=0,
//   TX_DATA=0, BUSY=0. TRST mid-shift aborts at once; no TX_VALID is issued.
//  FSM (addr = accepted byte with TMS=0, data = accepted byte with TMS=1):
//   IDLE    : addr==SYNC -> ADDR_HI; other addr ignored; data discarded, no TCK.
//   ADDR_HI : addr -> hi<=byte, ADDR_LO; data -> IDLE.
//   ADDR_LO : addr -> a={hi,byte}; a<NUM_TAPS: TAP_SEL<=1<<a, SEL;
//             else TAP_SEL<=0, IDLE. data -> IDLE.
//   SEL     : data -> load shreg, SHIFT. addr==DESEL -> TAP_SEL<=0, IDLE.
//             addr==SYNC -> TAP_SEL<=0, ADDR_HI. Other addr ignored.
//   SHIFT   : RX_READY=0. Runs 8 bits. For each bit, TDI<=shreg[0] at bit start.
//             TCK is low for TCK_DIV cycles, then high for TCK_DIV cycles.
//             TDO is sampled on the CLK edge that raises TCK.
//             After bit 7's high phase: TCK<=0, TDI<=1, -> SEL.
//  TAP_SEL updates 1 cycle after the accepting edge; it stays stable through
//   SHIFT.
//  Latency: byte accepted at edge 0 -> TX_VALID at edge 16*TCK_DIV+1.
//   RX_READY returns high in the same cycle.
//  Address is 16 bits. The hi byte takes part in the compare, so hi!=0 is out
//   of range.
//  Divider counter width is $clog2(TCK_DIV)+1. Bit counter width is 3; the
//   wrap from 7 ends SHIFT.
// CONFIGURATION
//  SCAN_READBACK_EN defined: TDO is shifted into TX_DATA MSB-first-in, so the
//   first bit lands in bit 0. TX_VALID pulses at the end of each byte.
//  Undefined: TDO is ignored, TX_DATA=0 and TX_VALID=0 always; shift timing is
//   unchanged.
// TESTING  (NUM_TAPS=4, TCK_DIV=2)
//  1 addr A5,00,02 -> TAP_SEL=4'b0100 one cycle after the third accept.
//  2 Tap 2 selected, TDO tied to TDI, data 7F -> exactly 8 TCK rises.
//    TDI=1,1,1,1,1,1,1,0 and RX_READY=0 throughout.
//    With SCAN_READBACK_EN: TX_VALID at accept+33 with TX_DATA=8'h7F.
//    Without it: TX_VALID stays 0.
//  3 Selected, then addr 5A -> TAP_SEL=0. A following data A5 -> no TCK edge,
//    TX_VALID=0.
//  4 addr A5,00,07 -> TAP_SEL stays 0, state IDLE. Then data 08 -> no TCK.
//  5 TRST pulse after the 3rd TCK rise of a shift -> TCK=0, TAP_SEL=0, no
//    TX_VALID. After release, addr A5,00,01 -> TAP_SEL=4'b0010.
//  6 addr A5, then data 11 (abort) -> IDLE. Then addr 00,02 ignored, TAP_SEL=0.

Source files
------------

// File: rtl/scan_tap_ctrl_if.sv
// Byte/scan interface between the UART receiver, scan_tap_ctrl and the tap pins.
// The slave modport is the controller view; the master modport is the surrounding logic view.
interface scan_tap_ctrl_if #(
  parameter int NUM_TAPS = 4
);
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic                tms;
  logic                rx_ready;
  logic [NUM_TAPS-1:0] tap_sel;
  logic                tck;
  logic                tdi;
  logic                tdo;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                busy;

  modport slave (
    input  rx_data, rx_valid, tms, tdo,
    output rx_ready, tap_sel, tck, tdi, tx_data, tx_valid, busy
  );

  modport master (
    output rx_data, rx_valid, tms, tdo,
    input  rx_ready, tap_sel, tck, tdi, tx_data, tx_valid, busy
  );
endinterface

// File: rtl/scan_tap_ctrl.sv
// Byte-level scan sequencer: decodes SYNC/address messages into a one-hot tap
// select and serialises data bytes LSB first onto TCK/TDI. Optional macro SCAN_READBACK_EN.
module scan_tap_ctrl #(
  parameter int          NUM_TAPS = 4,
  parameter int          TCK_DIV  = 2,
  parameter logic [7:0]  SYNC     = 8'hA5,
  parameter logic [7:0]  DESEL    = 8'h5A
) (
  input  logic          i_clk,
  input  logic          i_rst,
  scan_tap_ctrl_if.slave bus
);

  localparam int DIV_W = $clog2(TCK_DIV) + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR_HI = 3'd1,
    S_ADDR_LO = 3'd2,
    S_SEL     = 3'd3,
    S_SHIFT   = 3'd4
  } state_t;

  state_t              r_state;
  logic [7:0]          r_hi;
  logic [7:0]          r_shreg;
  logic [DIV_W-1:0]    r_div;
  logic [2:0]          r_bit;
  logic                r_start;
  logic [NUM_TAPS-1:0] r_tap_sel;
  logic                r_tck;
  logic                r_tdi;
  logic                r_rx_ready;
  logic [7:0]          r_tx_data;
  logic                r_tx_valid;
  logic                r_busy;
`ifdef SCAN_READBACK_EN
  logic [7:0]          r_cap;
`else
  logic                w_unused_tdo;
  assign w_unused_tdo = bus.tdo;
`endif

  logic                w_accept;
  logic [15:0]         w_addr;
  logic [NUM_TAPS-1:0] w_onehot;
  logic                w_in_range;
  logic                w_div_end;

  assign w_accept   = bus.rx_valid & r_rx_ready;
  assign w_addr     = {r_hi, bus.rx_data};
  assign w_in_range = |w_onehot;
  assign w_div_end  = (r_div == DIV_W'(TCK_DIV - 1));

  // The full 16-bit address is compared, so any non-zero hi byte selects nothing.
  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      if (w_addr == 16'(i)) begin
        w_onehot[i] = 1'b1;
      end else begin
        w_onehot[i] = 1'b0;
      end
    end
  end

  // Message decoder and bit-serial shifter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_hi       <= 8'h00;
      r_shreg    <= 8'h00;
      r_div      <= '0;
      r_bit      <= 3'd0;
      r_start    <= 1'b0;
      r_tap_sel  <= '0;
      r_tck      <= 1'b0;
      r_tdi      <= 1'b1;
      r_rx_ready <= 1'b1;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
`ifdef SCAN_READBACK_EN
      r_cap      <= 8'h00;
`endif
    end else begin
      r_tx_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && !bus.tms && (bus.rx_data == SYNC)) begin
            r_state <= S_ADDR_HI;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ADDR_HI: begin
          if (w_accept && bus.tms) begin
            r_state <= S_IDLE;
          end else if (w_accept) begin
            r_hi    <= bus.rx_data;
            r_state <= S_ADDR_LO;
          end else begin
            r_state <= S_ADDR_HI;
          end
        end
        S_ADDR_LO: begin
          if (w_accept && bus.tms) begin
            r_state <= S_IDLE;
          end else if (w_accept) begin
            r_tap_sel <= w_onehot;
            r_state   <= w_in_range ? S_SEL : S_IDLE;
          end else begin
            r_state <= S_ADDR_LO;
          end
        end
        S_SEL: begin
          if (w_accept && bus.tms) begin
            r_shreg    <= bus.rx_data;
            r_start    <= 1'b1;
            r_div      <= '0;
            r_bit      <= 3'd0;
            r_tck      <= 1'b0;
            r_rx_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_SHIFT;
          end else if (w_accept && (bus.rx_data == DESEL)) begin
            r_tap_sel <= '0;
            r_state   <= S_IDLE;
          end else if (w_accept && (bus.rx_data == SYNC)) begin
            r_tap_sel <= '0;
            r_state   <= S_ADDR_HI;
          end else begin
            r_state <= S_SEL;
          end
        end
        S_SHIFT: begin
          // The accepting edge only loads; bit 0 starts one cycle later.
          if (r_start) begin
            r_start <= 1'b0;
            r_tdi   <= r_shreg[0];
            r_div   <= '0;
          end else if (!r_tck && w_div_end) begin
            r_tck <= 1'b1;
            r_div <= '0;
`ifdef SCAN_READBACK_EN
            r_cap <= {bus.tdo, r_cap[7:1]};
`endif
          end else if (r_tck && w_div_end) begin
            r_tck <= 1'b0;
            r_div <= '0;
            r_bit <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
              r_tdi      <= 1'b1;
              r_rx_ready <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= S_SEL;
`ifdef SCAN_READBACK_EN
              r_tx_data  <= r_cap;
              r_tx_valid <= 1'b1;
`endif
            end else begin
              r_shreg <= {1'b0, r_shreg[7:1]};
              r_tdi   <= r_shreg[1];
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_tap_sel  <= '0;
          r_tck      <= 1'b0;
          r_tdi      <= 1'b1;
          r_rx_ready <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_ready = r_rx_ready;
  assign bus.tap_sel  = r_tap_sel;
  assign bus.tck      = r_tck;
  assign bus.tdi      = r_tdi;
  assign bus.tx_data  = r_tx_data;
  assign bus.tx_valid = r_tx_valid;
  assign bus.busy     = r_busy;

endmodule
